dpram_sync: RTL and testbench



---
 rtl/dpram_sync.sv | 152 +++++++++++++++
 tb/tb_dpram_sync.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_sync.sv
// Synchronous dual-port RAM: masked writes, selectable read-during-write,
// port-A-priority write collisions, optional output register and post-reset zero sweep.
module dpram_sync #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned AWIDTH  = 7,
  parameter int unsigned OREG    = 0,
  parameter int unsigned RDW_NEW = 0,
  parameter int unsigned CLEAR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] wdata_a,
  input  logic [DWIDTH-1:0] wmask_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [DWIDTH-1:0] wdata_b,
  input  logic [DWIDTH-1:0] wmask_b,
  output logic [DWIDTH-1:0] rdata_a,
  output logic              rvalid_a,
  output logic [DWIDTH-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              collision,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** AWIDTH;

  typedef enum logic {StIdle, StClr} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  logic [DWIDTH-1:0] mem [Depth];

  logic              idle, clr_we;
  logic              wr_a, wr_b, rd_a, rd_b;
  logic [DWIDTH-1:0] word_a, word_b;
  logic [DWIDTH-1:0] rsel_a, rsel_b;

  logic              s1_valid_a_q, s1_valid_b_q;
  logic [DWIDTH-1:0] s1_data_a_q, s1_data_b_q;
  logic              collision_q;

  function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old,
                                              input logic [DWIDTH-1:0] data,
                                              input logic [DWIDTH-1:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClr) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AWIDTH{1'b1}}) state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR != 0) ? StClr : StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == StClr);
  assign idle   = (state_q == StIdle) && !rst;
  assign clr_we = (state_q == StClr) && !rst;

  assign wr_a = idle & en_a & we_a;
  assign wr_b = idle & en_b & we_b;
  assign rd_a = idle & en_a & ~we_a;
  assign rd_b = idle & en_b & ~we_b;

  // Post-write word at each port's address: B applied first so A wins on overlapping bits.
  // On a same-address double write both words are identical.
  always_comb begin
    word_a = mem[addr_a];
    if (wr_b && (addr_b == addr_a)) word_a = merge(word_a, wdata_b, wmask_b);
    if (wr_a) word_a = merge(word_a, wdata_a, wmask_a);
    word_b = mem[addr_b];
    if (wr_b) word_b = merge(word_b, wdata_b, wmask_b);
    if (wr_a && (addr_a == addr_b)) word_b = merge(word_b, wdata_a, wmask_a);
  end

  assign rsel_a = (RDW_NEW != 0) ? word_a : mem[addr_a];
  assign rsel_b = (RDW_NEW != 0) ? word_b : mem[addr_b];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_a) mem[addr_a] <= word_a;
      if (wr_b) mem[addr_b] <= word_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_a_q <= 1'b0;
      s1_valid_b_q <= 1'b0;
      s1_data_a_q  <= '0;
      s1_data_b_q  <= '0;
      collision_q  <= 1'b0;
    end else begin
      s1_valid_a_q <= rd_a;
      s1_valid_b_q <= rd_b;
      if (rd_a) s1_data_a_q <= rsel_a;
      if (rd_b) s1_data_b_q <= rsel_b;
      collision_q  <= wr_a & wr_b & (addr_a == addr_b);
    end
  end

  assign collision = collision_q;

  if (OREG != 0) begin : g_oreg
    logic              out_valid_a_q, out_valid_b_q;
    logic [DWIDTH-1:0] out_data_a_q, out_data_b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_a_q <= 1'b0;
        out_valid_b_q <= 1'b0;
        out_data_a_q  <= '0;
        out_data_b_q  <= '0;
      end else begin
        out_valid_a_q <= s1_valid_a_q;
        out_valid_b_q <= s1_valid_b_q;
        if (s1_valid_a_q) out_data_a_q <= s1_data_a_q;
        if (s1_valid_b_q) out_data_b_q <= s1_data_b_q;
      end
    end

    assign rdata_a  = out_data_a_q;
    assign rvalid_a = out_valid_a_q;
    assign rdata_b  = out_data_b_q;
    assign rvalid_b = out_valid_b_q;
  end else begin : g_noreg
    assign rdata_a  = s1_data_a_q;
    assign rvalid_a = s1_valid_a_q;
    assign rdata_b  = s1_data_b_q;
    assign rvalid_b = s1_valid_b_q;
  end

endmodule

// File: tb/tb_dpram_sync.sv
// Bench for dpram_sync: two instances (OREG=0/RDW old, OREG=1/RDW new) on shared stimulus,
// checked by per-port scoreboards of {expected cycle, expected data}.
module tb_dpram_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wmask_a, wdata_b, wmask_b;

  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
  logic        col0, col1, busy0, busy1;

  always #5 clk = ~clk;

  dpram_sync #(.DWIDTH(16), .AWIDTH(4), .OREG(0), .RDW_NEW(0), .CLEAR(1)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .wmask_a(wmask_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .wmask_b(wmask_b),
    .rdata_a(rdata_a0), .rvalid_a(rvalid_a0), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .collision(col0), .busy(busy0)
  );

  dpram_sync #(.DWIDTH(16), .AWIDTH(4), .OREG(1), .RDW_NEW(1), .CLEAR(1)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .wmask_a(wmask_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .wmask_b(wmask_b),
    .rdata_a(rdata_a1), .rvalid_a(rvalid_a1), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .collision(col1), .busy(busy1)
  );

  typedef struct {
    logic        rst;
    logic        en_a, we_a;
    logic [3:0]  addr_a;
    logic [15:0] wdata_a, wmask_a;
    logic        en_b, we_b;
    logic [3:0]  addr_b;
    logic [15:0] wdata_b, wmask_b;
    logic [15:0] xa0, xb0, xa1, xb1;  // expected read data: instance 0 / instance 1
    logic        col;
  } vec_t;

  typedef struct {
    int          c;
    logic [15:0] d;
  } exp_t;

  // Scoreboard index: 0 = u0.a, 1 = u0.b, 2 = u1.a, 3 = u1.b
  exp_t        q[4][$];
  logic [15:0] last[4];
  int          cyc = 0;
  int          col_cyc = -1;
  int          sweep_left = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, req);
  endtask

  function automatic vec_t mk(input logic ea, input logic wa, input logic [3:0] aa,
                              input logic [15:0] da, input logic [15:0] ma,
                              input logic eb, input logic wb, input logic [3:0] ab,
                              input logic [15:0] db, input logic [15:0] mb,
                              input logic [15:0] xa0, input logic [15:0] xb0,
                              input logic [15:0] xa1, input logic [15:0] xb1,
                              input logic col);
    vec_t v;
    v.rst = 1'b0;
    v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.wdata_a = da; v.wmask_a = ma;
    v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.wdata_b = db; v.wmask_b = mb;
    v.xa0 = xa0; v.xb0 = xb0; v.xa1 = xa1; v.xb1 = xb1; v.col = col;
    return v;
  endfunction

  function automatic vec_t rstv();
    vec_t v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t idlev();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t wra(input logic [3:0] a, input logic [15:0] d, input logic [15:0] m);
    return mk(1, 1, a, d, m, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rda(input logic [3:0] a, input logic [15:0] x);
    return mk(1, 0, a, 0, 0, 0, 0, 0, 0, 0, x, 0, x, 0, 0);
  endfunction

  // Drive one cycle; expectations are queued only for accesses the RAM should accept.
  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst;
    en_a = v.en_a; we_a = v.we_a; addr_a = v.addr_a; wdata_a = v.wdata_a; wmask_a = v.wmask_a;
    en_b = v.en_b; we_b = v.we_b; addr_b = v.addr_b; wdata_b = v.wdata_b; wmask_b = v.wmask_b;
    if (!v.rst && sweep_left == 0) begin
      if (v.en_a && !v.we_a) begin
        e.c = cyc + 1; e.d = v.xa0; q[0].push_back(e);
        e.c = cyc + 2; e.d = v.xa1; q[2].push_back(e);
      end
      if (v.en_b && !v.we_b) begin
        e.c = cyc + 1; e.d = v.xb0; q[1].push_back(e);
        e.c = cyc + 2; e.d = v.xb1; q[3].push_back(e);
      end
      if (v.col) col_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      for (int p = 0; p < 4; p++) begin
        q[p].delete();
        last[p] = '0;
      end
      col_cyc = -1;
      sweep_left = 16;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end
    chk("busy_u0", int'(busy0), int'(sweep_left != 0));
    chk("busy_u1", int'(busy1), int'(sweep_left != 0));
  endtask

  task automatic mon(input int p, input logic rv, input logic [15:0] rd);
    exp_t e;
    while (q[p].size() > 0 && q[p][0].c < cyc) begin
      e = q[p].pop_front();
      n_chk++;
      $display("FAIL rvalid_missing port%0d: rvalid low at cycle %0d, required data %h",
               p, e.c, e.d);
    end
    if (rv) begin
      if (q[p].size() == 0) begin
        n_chk++;
        $display("FAIL rvalid_unexpected port%0d @cycle %0d: got data %h, required no rvalid",
                 p, cyc, rd);
      end else begin
        e = q[p].pop_front();
        chk($sformatf("rvalid_cycle_p%0d", p), cyc, e.c);
        chk($sformatf("rdata_p%0d", p), int'(rd), int'(e.d));
        last[p] = e.d;
      end
    end else begin
      chk($sformatf("rdata_hold_p%0d", p), int'(rd), int'(last[p]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, rvalid_a0, rdata_a0);
      mon(1, rvalid_b0, rdata_b0);
      mon(2, rvalid_a1, rdata_a1);
      mon(3, rvalid_b1, rdata_b1);
      if (col0 || cyc == col_cyc) chk("collision_u0", int'(col0), int'(cyc == col_cyc));
      if (col1 || cyc == col_cyc) chk("collision_u1", int'(col1), int'(cyc == col_cyc));
    end
  end

  vec_t tbl[14];

  initial begin
    logic [15:0] d;

    // mk(ea,wa,aa,da,ma, eb,wb,ab,db,mb, xa0,xb0,xa1,xb1, col)
    tbl[0]  = wra(3, 16'hFFFF, 16'hFFFF);
    tbl[1]  = wra(3, 16'h0000, 16'h00F0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 16'hFF0F, 0, 16'hFF0F, 0);
    tbl[3]  = mk(1, 1, 5, 16'h1234, 16'hFF00, 1, 1, 5, 16'hABCD, 16'hFFFF, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 5, 0, 0, 1, 0, 5, 0, 0, 16'h12CD, 16'h12CD, 16'h12CD, 16'h12CD, 0);
    tbl[5]  = wra(7, 16'h1111, 16'hFFFF);
    tbl[6]  = mk(1, 1, 7, 16'h2222, 16'hFFFF, 1, 0, 7, 0, 0, 0, 16'h1111, 0, 16'h2222, 0);
    tbl[7]  = mk(1, 0, 3, 0, 0, 1, 0, 7, 0, 0, 16'hFF0F, 16'h2222, 16'hFF0F, 16'h2222, 0);
    tbl[8]  = mk(1, 0, 9, 0, 0, 1, 1, 9, 16'hABFF, 16'h0F0F, 16'h0000, 0, 16'h0B0F, 0, 0);
    tbl[9]  = mk(1, 0, 9, 0, 0, 1, 1, 9, 16'hFFFF, 16'h0000, 16'h0B0F, 0, 16'h0B0F, 0, 0);
    tbl[10] = mk(1, 1, 10, 16'h5555, 16'hF0F0, 1, 1, 10, 16'hAAAA, 16'h0FFF, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 1, 12, 16'h1357, 16'hFFFF, 1, 1, 13, 16'h2468, 16'hFFFF, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 12, 0, 0, 1, 0, 10, 0, 0, 16'h1357, 16'h5A5A, 16'h1357, 16'h5A5A, 0);
    tbl[13] = mk(1, 0, 13, 0, 0, 1, 0, 12, 0, 0, 16'h2468, 16'h1357, 16'h2468, 16'h1357, 0);

    step(rstv());
    mon_on = 1'b1;

    // Interrupted sweep, then a full sweep; writes issued while busy must be dropped.
    for (int i = 0; i < 9; i++) step(wra(0, 16'hFFFF, 16'hFFFF));
    step(rstv());
    for (int i = 0; i < 16; i++)
      step(mk(1, 1, 0, 16'hFFFF, 16'hFFFF, 1, 0, 4'(i), 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      step(mk(1, 0, 4'(i), 0, 0, 1, 0, 4'(15 - i), 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 14; i++) step(tbl[i]);

    // Back-to-back reads, then a disabled access that must leave rdata alone.
    for (int i = 0; i < 8; i++) begin
      d = 16'(i + 1) * 16'h1001;
      step(wra(4'(i), d, 16'hFFFF));
    end
    for (int i = 0; i < 8; i++) begin
      d = 16'(i + 1) * 16'h1001;
      step(rda(4'(i), d));
    end
    step(mk(0, 0, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(idlev());

    // Reset with a read in flight: the registered-output instance must drop it.
    step(rda(2, 16'h3003));
    step(rstv());
    for (int i = 0; i < 16; i++) step(idlev());
    step(rda(2, 16'h0000));
    for (int i = 0; i < 3; i++) step(idlev());

    for (int p = 0; p < 4; p++) chk($sformatf("queue_drain_p%0d", p), q[p].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
